// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: word widths,
// chip-enable levels, the fetch state encoding and the default reset PC.
package inst_fetch_pkg;

    localparam int          INST_ADDR_W      = 32;
    localparam int          INST_DATA_W      = 32;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        CHIP_ENABLE      = 1'b1;
    localparam logic        CHIP_DISABLE     = 1'b0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALLED = 2'd2
    } fetch_state_e;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register. A flush always clears it; a bubble request
// clears it; a capture loads the fetched PC and instruction; otherwise
// the register holds so a stalled ID stage keeps its instruction.
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              bubble_i,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] inst_q,  inst_d;
    logic              valid_q, valid_d;

    // Select flush/bubble, capture or hold for the next ID contents
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i || bubble_i) begin
            pc_d    = '0;
            inst_d  = '0;
            valid_d = 1'b0;
        end else if (capture_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    // Pipeline register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign id_valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC and the fetch FSM, drives the
// instruction ROM and feeds the IF/ID register.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall counters.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic              id_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic              fetch_active;
    logic              bubble;
    logic              capture;

    // IDLE is the only state in which the ROM is not being read
    assign fetch_active = (state_q != IDLE);
    assign bubble       = !fetch_active || (stall_if_i && !stall_id_i);
    assign capture      = fetch_active && !stall_if_i;
    assign rom_ce_o     = fetch_active ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr_o   = pc_q;

    // Next state and next PC: flush beats stall beats branch beats increment
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH, STALLED: begin
                if (flush_i) begin
                    pc_d    = new_pc_i & ALIGN_MASK;
                    state_d = FETCH;
                end else if (stall_if_i) begin
                    state_d = STALLED;
                end else if (branch_flag_i) begin
                    pc_d    = branch_target_i & ALIGN_MASK;
                    state_d = FETCH;
                end else begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & ALIGN_MASK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .bubble_i   (bubble),
        .capture_i  (capture),
        .pc_i       (pc_q),
        .inst_i     (rom_inst_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counts of valid captures and stalled fetch cycles
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture && !flush_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (fetch_active && stall_if_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= ZERO_WORD;
            stall_cnt_q <= ZERO_WORD;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : inst_fetch
